// File: rtl/mem_responder_if.sv
// Bus bundle between the CPU/loader side and mem_responder.
//   master: CPU read/write port and loader stream drivers, observes status.
//   slave : the responder; returns rData and the status outputs.
//   rAdd/rData   CPU read address / combinational read data
//   wen/wAdd/wData CPU write port
//   ld_valid/ld_byte/ld_done/ld_ready loader byte stream
//   run, ld_count, wr_count  status
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 16
) ();
  logic [15:0]     rAdd;
  logic [7:0]      rData;
  logic            wen;
  logic [15:0]     wAdd;
  logic [7:0]      wData;
  logic            ld_valid;
  logic [7:0]      ld_byte;
  logic            ld_done;
  logic            ld_ready;
  logic            run;
  logic [ADDR_W:0] ld_count;
  logic [15:0]     wr_count;

  modport master (
    output rAdd, wen, wAdd, wData, ld_valid, ld_byte, ld_done,
    input  rData, ld_ready, run, ld_count, wr_count
  );

  modport slave (
    input  rAdd, wen, wAdd, wData, ld_valid, ld_byte, ld_done,
    output rData, ld_ready, run, ld_count, wr_count
  );
endinterface

// File: rtl/mem_responder.sv
// Byte-wide memory target for a CPU with split read/write ports.
// After reset it zero-fills the store (CLEAR), accepts a program image over a
// valid/ready byte stream (LOAD), then releases the CPU (RUN) and serves its
// byte accesses with a zero-latency combinational read port.
// Ports:
//   clk    clock, all state changes on posedge
//   reset  synchronous active-high reset
//   bus    mem_responder_if slave modport (CPU ports, loader stream, status)
module mem_responder #(
  parameter int unsigned ADDR_W     = 16,
  parameter bit          SKIP_CLEAR = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int unsigned Depth = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ClrLast = '1;
  localparam logic [ADDR_W:0]   LdFull  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    StClear = 2'd0,
    StLoad  = 2'd1,
    StRun   = 2'd2
  } state_e;

  localparam state_e ResetState = SKIP_CLEAR ? StLoad : StClear;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [ADDR_W:0]   ld_count_q, ld_count_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [7:0]        mem_q [Depth];

  // Single store write port, shared by clear, load and CPU writes (never concurrent).
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    ld_count_d = ld_count_q;
    wr_count_d = wr_count_q;
    mem_we     = 1'b0;
    mem_waddr  = clr_ptr_q;
    mem_wdata  = 8'h00;

    case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == ClrLast) begin
          state_d = StLoad;
        end
      end

      StLoad: begin
        if (bus.ld_valid && (ld_count_q != LdFull)) begin
          mem_we     = 1'b1;
          mem_waddr  = ld_count_q[ADDR_W-1:0];
          mem_wdata  = bus.ld_byte;
          ld_count_d = ld_count_q + (ADDR_W + 1)'(1);
        end
        // A full store ends the load without waiting for ld_done.
        if (bus.ld_done || (ld_count_d == LdFull)) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (bus.wen) begin
          mem_we    = 1'b1;
          mem_waddr = bus.wAdd[ADDR_W-1:0];
          mem_wdata = bus.wData;
          if (wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
          end
        end
      end

      default: begin
        // Illegal code: restart a full clear.
        state_d   = StClear;
        clr_ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ResetState;
      clr_ptr_q  <= '0;
      ld_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      ld_count_q <= ld_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Store has no reset; contents survive reset unless CLEAR runs.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Read returns the pre-edge byte on a same-address write, since the store updates at posedge.
  assign bus.rData    = (state_q == StRun) ? mem_q[bus.rAdd[ADDR_W-1:0]] : 8'h00;
  assign bus.ld_ready = (state_q == StLoad);
  assign bus.run      = (state_q == StRun);
  assign bus.ld_count = ld_count_q;
  assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rAdd = '0;
  logic        wen = 1'b0;
  logic [15:0] wAdd = '0;
  logic [7:0]  wData = '0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_done = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // if0/dut0: normal clear; if1/dut1: SKIP_CLEAR, same stimulus.
  mem_responder_if #(.ADDR_W(4)) if0 ();
  mem_responder_if #(.ADDR_W(4)) if1 ();

  assign if0.rAdd = rAdd;      assign if1.rAdd = rAdd;
  assign if0.wen = wen;        assign if1.wen = wen;
  assign if0.wAdd = wAdd;      assign if1.wAdd = wAdd;
  assign if0.wData = wData;    assign if1.wData = wData;
  assign if0.ld_valid = ld_valid; assign if1.ld_valid = ld_valid;
  assign if0.ld_byte = ld_byte;   assign if1.ld_byte = ld_byte;
  assign if0.ld_done = ld_done;   assign if1.ld_done = ld_done;

  mem_responder #(.ADDR_W(4), .SKIP_CLEAR(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  mem_responder #(.ADDR_W(4), .SKIP_CLEAR(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of dut0: phase counters and a byte array.
  logic [7:0] m_mem [16];
  int  m_clear_left = 0;
  bit  m_loading = 0;
  bit  m_running = 0;
  int  m_ldc = 0;
  int  m_wrc = 0;
  bit  m_valid = 0;

  initial for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;

  always @(posedge clk) begin
    if (reset) begin
      m_clear_left = 16;
      m_loading = 0;
      m_running = 0;
      m_ldc = 0;
      m_wrc = 0;
      m_valid = 1;
    end else if (m_clear_left > 0) begin
      m_mem[16 - m_clear_left] = 8'h00;
      m_clear_left--;
      if (m_clear_left == 0) m_loading = 1;
    end else if (m_loading) begin
      if (ld_valid && m_ldc < 16) begin
        m_mem[m_ldc] = ld_byte;
        m_ldc++;
      end
      if (ld_done || m_ldc == 16) begin
        m_loading = 0;
        m_running = 1;
      end
    end else if (m_running && wen) begin
      m_mem[wAdd % 16] = wData;
      if (m_wrc < 65535) m_wrc++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("run", if0.run, m_running);
      chk("ld_ready", if0.ld_ready, m_loading);
      chk("ld_count", if0.ld_count, m_ldc);
      chk("wr_count", if0.wr_count, m_wrc);
      chk("rData", if0.rData, m_running ? m_mem[rAdd[3:0]] : 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic rd_chk(input logic [15:0] a, input logic [7:0] e0, input bit c1,
                        input logic [7:0] e1);
    rAdd = a;
    @(negedge clk);
    chk("lit_rd0", if0.rData, e0);
    if (c1) chk("lit_rd1", if1.rData, e1);
    tick();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!if0.ld_ready && n < 40) begin
      tick();
      n++;
    end
    chk("ld_ready_wait", if0.ld_ready, 1'b1);
  endtask

  initial begin
    // 1: reset, then 16 clear cycles
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rAdd = 16'(i);
      @(negedge clk);
      chk("lit_clr_run", if0.run, 1'b0);
      chk("lit_clr_rdy", if0.ld_ready, 1'b0);
      chk("lit_clr_rdata", if0.rData, 8'h00);
      if (i == 0) chk("lit_skip_rdy", if1.ld_ready, 1'b1);
      tick();
    end
    @(negedge clk);
    chk("lit_rdy17", if0.ld_ready, 1'b1);
    tick();

    // 2: gapped load then ld_done
    ld(8'h81); tick(); ld(8'h2A); ld(8'h00); tick(); tick(); ld(8'h01);
    ld_done = 1'b1; tick(); ld_done = 1'b0;
    @(negedge clk);
    chk("lit_run", if0.run, 1'b1);
    chk("lit_ldc4", if0.ld_count, 5'd4);
    chk("lit_run1", if1.run, 1'b1);
    tick();
    rd_chk(16'd0, 8'h81, 1, 8'h81);
    rd_chk(16'd1, 8'h2A, 1, 8'h2A);
    rd_chk(16'd2, 8'h00, 1, 8'h00);
    rd_chk(16'd3, 8'h01, 1, 8'h01);
    rd_chk(16'd4, 8'h00, 0, 8'h00);

    // 3: same-address read during write returns old byte
    wen = 1'b1; wAdd = 16'd5; wData = 8'h7F; rAdd = 16'd5;
    @(negedge clk);
    chk("lit_rw_old", if0.rData, 8'h00);
    tick();
    wen = 1'b0;
    @(negedge clk);
    chk("lit_rw_new", if0.rData, 8'h7F);
    chk("lit_wrc1", if0.wr_count, 16'd1);
    tick();

    // 4: big-endian word write wrapping from top address to 0
    wen = 1'b1; wAdd = 16'hFFFF; wData = 8'hBE; tick();
    wAdd = 16'h0000; wData = 8'hEF; tick();
    wen = 1'b0;
    rd_chk(16'd15, 8'hBE, 1, 8'hBE);
    rd_chk(16'd0, 8'hEF, 1, 8'hEF);
    rd_chk(16'hFFF0, 8'hEF, 1, 8'hEF);
    @(negedge clk);
    chk("lit_wrc3", if0.wr_count, 16'd3);
    tick();

    // 5: full 16-byte stream enters RUN without ld_done
    reset = 1'b1; tick(); reset = 1'b0;
    wait_ready();
    for (int i = 0; i < 16; i++) ld(8'(8'h30 + i));
    @(negedge clk);
    chk("lit_full_run", if0.run, 1'b1);
    chk("lit_full_ldc", if0.ld_count, 5'd16);
    chk("lit_full_ldc1", if1.ld_count, 5'd16);
    tick();
    ld(8'hEE);
    @(negedge clk);
    chk("lit_ldc_hold", if0.ld_count, 5'd16);
    tick();
    rd_chk(16'd0, 8'h30, 1, 8'h30);
    rd_chk(16'd15, 8'h3F, 1, 8'h3F);

    // 6: reset mid-RUN re-zeroes dut0; dut1 keeps contents
    wen = 1'b1; wAdd = 16'd3; wData = 8'hC3; tick(); wen = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    @(negedge clk);
    chk("lit_rst_run", if0.run, 1'b0);
    chk("lit_rst_rdy", if0.ld_ready, 1'b0);
    chk("lit_rst_wrc", if0.wr_count, 16'd0);
    chk("lit_rst_rdy1", if1.ld_ready, 1'b1);
    tick();
    wait_ready();
    ld_done = 1'b1; tick(); ld_done = 1'b0;
    for (int i = 0; i < 16; i++) rd_chk(16'(i), 8'h00, 1, (i == 3) ? 8'hC3 : 8'(8'h30 + i));
    @(negedge clk);
    chk("lit_post_wrc", if0.wr_count, 16'd0);
    chk("lit_post_wrc1", if1.wr_count, 16'd0);
    chk("lit_post_ldc1", if1.ld_count, 5'd0);
    chk("lit_post_run", if0.run, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
